// File: rtl/axi_dma_w_split.sv
// -----------------------------------------------------------------------------
// axi_dma_w_split
//
// Multi-burst AXI4 write DMA engine. Takes one command (base byte address and
// total beat count) plus a valid/ready data stream. It splits the transfer into
// INCR bursts. Each burst is limited by MAX_BURST and by the 4 KB page that
// holds the current address. Bursts go out one at a time on AW/W/B, so the next
// AW is issued only after the previous B response.
//
// Optional feature (macro AXI_DMA_W_ERR_ABORT_EN):
//   defined   - a non-OKAY bresp ends the command right after that response.
//   undefined - a non-OKAY bresp only sets the sticky error flag, and every
//               burst of the command still completes.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start                 command pulse, honoured only while busy=0
//   cmd_addr, cmd_total   base byte address (forced to bus alignment), beats
//   busy, done, error     command in progress, end-of-command pulse, sticky
//                         bresp error flag (cleared on an accepted start)
//   s_valid/s_ready/s_data/s_strb   upstream write-data stream
//   m_axi_aw*             AXI write-address channel (constant fields fixed)
//   m_axi_w*              AXI write-data channel (pass-through of the stream)
//   m_axi_b*              AXI write-response channel
// -----------------------------------------------------------------------------
module axi_dma_w_split #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 256,
    parameter int LEN_W     = 8,
    parameter int TOTAL_W   = 16,
    parameter int MAX_BURST = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [TOTAL_W-1:0]    cmd_total,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_W-1:0]     s_data,
    input  logic [DATA_W/8-1:0]   s_strb,
    output logic [3:0]            m_axi_awid,
    output logic [ADDR_W-1:0]     m_axi_awaddr,
    output logic [LEN_W-1:0]      m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic                  m_axi_awlock,
    output logic [3:0]            m_axi_awcache,
    output logic [2:0]            m_axi_awprot,
    output logic [3:0]            m_axi_awqos,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_W-1:0]     m_axi_wdata,
    output logic [DATA_W/8-1:0]   m_axi_wstrb,
    output logic                  m_axi_wlast,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready
);

    localparam int BYTES = DATA_W / 8;
    localparam int SIZE  = $clog2(BYTES);
    // A burst may be 2^LEN_W beats long, so it needs one bit more than awlen.
    localparam int BW    = LEN_W + 1;
    // Wide enough for the remaining count and for the 4 KB page beat count.
    localparam int CW    = (TOTAL_W > 13) ? TOTAL_W : 13;

`ifdef AXI_DMA_W_ERR_ABORT_EN
    localparam logic ABORT_EN = 1'b1;
`else
    localparam logic ABORT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [TOTAL_W-1:0]   remaining_q, remaining_d;
    logic [BW-1:0]        burst_q, burst_d;
    logic [BW-1:0]        beat_q, beat_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 error_q, error_d;

    logic [12:0]          page_beats_s;
    logic [CW-1:0]        rem_ext_s, max_ext_s, page_ext_s, min1_s, min2_s;
    logic [BW-1:0]        burst_s;
    logic                 w_hs_s;
    logic                 last_beat_s;
    logic                 bad_resp_s;

    // Burst size = min(remaining, MAX_BURST, beats left in the current 4 KB page)
    always_comb begin
        page_beats_s = (13'd4096 - {1'b0, addr_q[11:0]}) >> SIZE;
        rem_ext_s    = CW'(remaining_q);
        max_ext_s    = CW'(MAX_BURST);
        page_ext_s   = CW'(page_beats_s);
        min1_s       = (rem_ext_s < max_ext_s) ? rem_ext_s : max_ext_s;
        min2_s       = (page_ext_s < min1_s) ? page_ext_s : min1_s;
        burst_s      = BW'(min2_s);
    end

    assign w_hs_s      = (state_q == DATA) && s_valid && m_axi_wready;
    assign last_beat_s = (beat_q == (burst_q - BW'(1)));
    assign bad_resp_s  = (m_axi_bresp != 2'b00);

    // AW channel: constant attributes, and a payload that stays stable while in ADDR
    assign m_axi_awid    = 4'd0;
    assign m_axi_awsize  = 3'(SIZE);
    assign m_axi_awburst = 2'b01;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = 4'h2;
    assign m_axi_awprot  = 3'b010;
    assign m_axi_awqos   = 4'd0;
    assign m_axi_awvalid = (state_q == ADDR);
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = LEN_W'(burst_s - BW'(1));

    // W channel: the stream passes straight through, but only while in DATA
    assign m_axi_wvalid  = (state_q == DATA) && s_valid;
    assign s_ready       = (state_q == DATA) && m_axi_wready;
    assign m_axi_wdata   = s_data;
    assign m_axi_wstrb   = s_strb;
    assign m_axi_wlast   = (state_q == DATA) && last_beat_s;

    assign m_axi_bready  = (state_q == RESP);

    assign busy  = busy_q;
    assign done  = done_q;
    assign error = error_q;

    // Next-state and datapath updates for the command/burst sequencer
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        burst_d     = burst_q;
        beat_d      = beat_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        error_d     = error_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    error_d = 1'b0;
                    if (cmd_total != {TOTAL_W{1'b0}}) begin
                        addr_d      = cmd_addr & ~ADDR_W'(BYTES - 1);
                        remaining_d = cmd_total;
                        busy_d      = 1'b1;
                        state_d     = ADDR;
                    end else begin
                        // An empty command finishes at once with no AXI traffic.
                        done_d = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ADDR: begin
                if (m_axi_awready) begin
                    burst_d = burst_s;
                    beat_d  = {BW{1'b0}};
                    state_d = DATA;
                end else begin
                    state_d = ADDR;
                end
            end
            DATA: begin
                if (w_hs_s) begin
                    if (last_beat_s) begin
                        addr_d      = addr_q + (ADDR_W'(burst_q) << SIZE);
                        remaining_d = remaining_q - TOTAL_W'(burst_q);
                        state_d     = RESP;
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end else begin
                    state_d = DATA;
                end
            end
            RESP: begin
                if (m_axi_bvalid) begin
                    error_d = error_q | bad_resp_s;
                    if ((remaining_q == {TOTAL_W{1'b0}}) || (ABORT_EN && bad_resp_s)) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = ADDR;
                    end
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any transfer in flight at once
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= {ADDR_W{1'b0}};
            remaining_q <= {TOTAL_W{1'b0}};
            burst_q     <= {BW{1'b0}};
            beat_q      <= {BW{1'b0}};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            burst_q     <= burst_d;
            beat_q      <= beat_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

endmodule

// File: tb/tb_axi_dma_w_split.sv
module tb_axi_dma_w_split;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 256;
    localparam int LEN_W     = 8;
    localparam int TOTAL_W   = 16;
    localparam int MAX_BURST = 16;
    localparam int STRB_W    = DATA_W / 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic                 start;
    logic [ADDR_W-1:0]    cmd_addr;
    logic [TOTAL_W-1:0]   cmd_total;
    logic                 busy, done, error;
    logic                 s_valid, s_ready;
    logic [DATA_W-1:0]    s_data;
    logic [STRB_W-1:0]    s_strb;
    logic [3:0]           m_axi_awid;
    logic [ADDR_W-1:0]    m_axi_awaddr;
    logic [LEN_W-1:0]     m_axi_awlen;
    logic [2:0]           m_axi_awsize;
    logic [1:0]           m_axi_awburst;
    logic                 m_axi_awlock;
    logic [3:0]           m_axi_awcache;
    logic [2:0]           m_axi_awprot;
    logic [3:0]           m_axi_awqos;
    logic                 m_axi_awvalid, m_axi_awready;
    logic [DATA_W-1:0]    m_axi_wdata;
    logic [STRB_W-1:0]    m_axi_wstrb;
    logic                 m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic [1:0]           m_axi_bresp;
    logic                 m_axi_bvalid, m_axi_bready;

    axi_dma_w_split #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W),
        .TOTAL_W(TOTAL_W), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .cmd_addr(cmd_addr), .cmd_total(cmd_total),
        .busy(busy), .done(done), .error(error),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_strb(s_strb),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
        .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
    );

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
    } aw_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
    } beat_t;

    aw_t   exp_aw_q[$];
    beat_t exp_w_q[$];
    beat_t src_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Counters and slave state, written only by the bus process below
    int aw_cnt, w_cnt, b_cnt, done_cnt;
    int beat_in_burst, b_pending, b_num, aw_wait;
    logic [LEN_W-1:0] cur_len;

    // Scenario configuration, written by the test tasks
    int aw_hold   = 0;
    bit rand_w    = 1'b0;
    bit rand_s    = 1'b0;
    bit err_first = 1'b0;
    bit flush_req = 1'b0;

    // AXI slave, stream source and monitor: observe at negedge, drive at posedge+1
    initial begin
        bit aw_hs, s_hs, b_hs, aw_wait_prev, exp_last;
        logic [ADDR_W-1:0] prev_awaddr;
        logic [LEN_W-1:0]  prev_awlen;
        aw_t   ea;
        beat_t ew;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
        s_valid = 1'b0; s_data = '0; s_strb = '0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; done_cnt = 0;
        beat_in_burst = 0; b_pending = 0; b_num = 0; aw_wait = 0; cur_len = '0;
        aw_wait_prev = 1'b0; prev_awaddr = '0; prev_awlen = '0;
        forever begin
            @(negedge clk);
            aw_hs = !rst && m_axi_awvalid && m_axi_awready;
            s_hs  = !rst && s_valid && s_ready;
            b_hs  = !rst && m_axi_bvalid && m_axi_bready;
            if (m_axi_awvalid && !rst) begin
                if (aw_wait_prev) begin
                    n_checks++;
                    if (m_axi_awaddr !== prev_awaddr || m_axi_awlen !== prev_awlen) begin
                        n_fail++;
                        $display("FAIL aw_stable: awaddr=%h awlen=%0d, required awaddr=%h awlen=%0d",
                                 m_axi_awaddr, m_axi_awlen, prev_awaddr, prev_awlen);
                    end
                end
                aw_wait_prev = !m_axi_awready;
                prev_awaddr  = m_axi_awaddr;
                prev_awlen   = m_axi_awlen;
            end else begin
                aw_wait_prev = 1'b0;
            end
            if (aw_hs) begin
                aw_cnt++;
                n_checks++;
                if (exp_aw_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL aw_unexpected: awaddr=%h awlen=%0d, required no burst", m_axi_awaddr, m_axi_awlen);
                end else begin
                    ea = exp_aw_q.pop_front();
                    if (m_axi_awaddr !== ea.addr || m_axi_awlen !== ea.len) begin
                        n_fail++;
                        $display("FAIL aw_burst: awaddr=%h awlen=%0d, required awaddr=%h awlen=%0d",
                                 m_axi_awaddr, m_axi_awlen, ea.addr, ea.len);
                    end
                end
                n_checks++;
                if ({m_axi_awid, m_axi_awsize, m_axi_awburst, m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awqos}
                    !== {4'd0, 3'd5, 2'b01, 1'b0, 4'h2, 3'b010, 4'd0}) begin
                    n_fail++;
                    $display("FAIL aw_const: id=%0d size=%0d burst=%0d lock=%0d cache=%h prot=%0d qos=%0d, required 0/5/1/0/2/2/0",
                             m_axi_awid, m_axi_awsize, m_axi_awburst, m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awqos);
                end
                cur_len = m_axi_awlen;
                beat_in_burst = 0;
            end
            if (!rst && m_axi_wvalid && m_axi_wready) begin
                w_cnt++;
                n_checks++;
                if (exp_w_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL w_unexpected: wdata=%h, required no beat", m_axi_wdata);
                end else begin
                    ew = exp_w_q.pop_front();
                    if (m_axi_wdata !== ew.data || m_axi_wstrb !== ew.strb) begin
                        n_fail++;
                        $display("FAIL w_data: wdata=%h wstrb=%h, required wdata=%h wstrb=%h",
                                 m_axi_wdata, m_axi_wstrb, ew.data, ew.strb);
                    end
                end
                exp_last = (beat_in_burst == int'(cur_len));
                n_checks++;
                if (m_axi_wlast !== exp_last) begin
                    n_fail++;
                    $display("FAIL w_last: wlast=%0b at beat %0d, required %0b", m_axi_wlast, w_cnt, exp_last);
                end
                if (exp_last) begin
                    beat_in_burst = 0;
                    b_pending++;
                end else begin
                    beat_in_burst++;
                end
            end
            if (b_hs) b_cnt++;
            if (done === 1'b1) done_cnt++;

            @(posedge clk);
            #1;
            if (aw_hs) begin
                m_axi_awready = 1'b0;
                aw_wait = 0;
            end else if (m_axi_awvalid && !m_axi_awready) begin
                if (aw_wait >= aw_hold) m_axi_awready = 1'b1;
                else aw_wait++;
            end
            m_axi_wready = rand_w ? 1'($urandom_range(0, 1)) : 1'b1;
            if (s_hs) begin
                if (src_q.size() > 0) void'(src_q.pop_front());
                s_valid = 1'b0;
            end
            if (!s_valid && src_q.size() > 0 && (!rand_s || $urandom_range(0, 1) == 1)) begin
                s_valid = 1'b1;
                s_data  = src_q[0].data;
                s_strb  = src_q[0].strb;
            end
            if (b_hs) m_axi_bvalid = 1'b0;
            if (!m_axi_bvalid && b_pending > 0) begin
                m_axi_bvalid = 1'b1;
                m_axi_bresp  = (err_first && b_num == 0) ? 2'b10 : 2'b00;
                b_pending--;
                b_num++;
            end
            if (flush_req) begin
                exp_aw_q.delete(); exp_w_q.delete(); src_q.delete();
                s_valid = 1'b0; m_axi_awready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
                aw_cnt = 0; w_cnt = 0; b_cnt = 0; done_cnt = 0;
                beat_in_burst = 0; b_pending = 0; b_num = 0; aw_wait = 0;
                aw_wait_prev = 1'b0;
                flush_req = 1'b0;
            end
        end
    end

    task automatic flush_bench();
        flush_req = 1'b1;
        @(posedge clk); #2;
    endtask

    task automatic push_beats(input int n_src, input int n_exp);
        beat_t b;
        for (int i = 0; i < n_src; i++) begin
            b.data = {8{$urandom()}};
            b.strb = $urandom();
            src_q.push_back(b);
            if (i < n_exp) exp_w_q.push_back(b);
        end
    endtask

    task automatic push_aw(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l);
        aw_t e;
        e.addr = a;
        e.len  = l;
        exp_aw_q.push_back(e);
    endtask

    task automatic issue_cmd(input logic [ADDR_W-1:0] a, input logic [TOTAL_W-1:0] t);
        start = 1'b1; cmd_addr = a; cmd_total = t;
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound, output bit ok);
        int k = 0;
        while (done !== 1'b1 && k < bound) begin
            @(posedge clk); #2;
            k++;
        end
        ok = (done === 1'b1);
        repeat (3) begin @(posedge clk); #2; end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; cmd_addr = '0; cmd_total = '0;
        repeat (3) begin @(posedge clk); #2; end
        n_checks++;
        if ({busy, done, error, m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready, s_ready} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_outputs: busy/done/error/awvalid/wvalid/wlast/bready/s_ready=%b, required 00000000",
                     {busy, done, error, m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready, s_ready});
        end
        rst = 1'b0;
        flush_bench();
    endtask

    task automatic test_three_bursts();
        bit ok;
        push_beats(40, 40);
        push_aw(32'h1000, 8'd15); push_aw(32'h1200, 8'd15); push_aw(32'h1400, 8'd7);
        issue_cmd(32'h1000, 16'd40);
        n_checks++;
        if (m_axi_awvalid !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL t1_aw_rise: awvalid=%0b busy=%0b one cycle after start, required 1 1", m_axi_awvalid, busy);
        end
        wait_done(2000, ok);
        n_checks++;
        if (!ok || done_cnt != 1 || aw_cnt != 3 || w_cnt != 40 || b_cnt != 3) begin
            n_fail++;
            $display("FAIL t1_counts: done_seen=%0b dones=%0d aw=%0d w=%0d b=%0d, required 1 1 3 40 3",
                     ok, done_cnt, aw_cnt, w_cnt, b_cnt);
        end
        n_checks++;
        if (error !== 1'b0 || busy !== 1'b0 || exp_aw_q.size() != 0 || exp_w_q.size() != 0) begin
            n_fail++;
            $display("FAIL t1_end: error=%0b busy=%0b aw_left=%0d w_left=%0d, required 0 0 0 0",
                     error, busy, exp_aw_q.size(), exp_w_q.size());
        end
        flush_bench();
    endtask

    task automatic test_4k_boundary();
        bit ok;
        push_beats(10, 10);
        push_aw(32'h1F80, 8'd3); push_aw(32'h2000, 8'd5);
        // Misaligned low bits must be dropped by the engine.
        issue_cmd(32'h1F9F, 16'd10);
        wait_done(2000, ok);
        n_checks++;
        if (!ok || done_cnt != 1 || aw_cnt != 2 || w_cnt != 10 || exp_aw_q.size() != 0) begin
            n_fail++;
            $display("FAIL t2_split: done_seen=%0b dones=%0d aw=%0d w=%0d aw_left=%0d, required 1 1 2 10 0",
                     ok, done_cnt, aw_cnt, w_cnt, exp_aw_q.size());
        end
        flush_bench();
        push_beats(3, 3);
        push_aw(32'h0FE0, 8'd0); push_aw(32'h1000, 8'd1);
        issue_cmd(32'h0FE0, 16'd3);
        wait_done(2000, ok);
        n_checks++;
        if (!ok || aw_cnt != 2 || w_cnt != 3 || exp_aw_q.size() != 0) begin
            n_fail++;
            $display("FAIL t2_last_beat_page: done_seen=%0b aw=%0d w=%0d aw_left=%0d, required 1 2 3 0",
                     ok, aw_cnt, w_cnt, exp_aw_q.size());
        end
        flush_bench();
    endtask

    task automatic test_zero_total();
        issue_cmd(32'h4000, 16'd0);
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || m_axi_awvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL t3_zero_first: done=%0b busy=%0b awvalid=%0b, required 1 0 0", done, busy, m_axi_awvalid);
        end
        @(posedge clk); #2;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || m_axi_awvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL t3_zero_next: done=%0b busy=%0b awvalid=%0b, required 0 0 0", done, busy, m_axi_awvalid);
        end
        repeat (3) begin @(posedge clk); #2; end
        n_checks++;
        if (aw_cnt != 0 || done_cnt != 1) begin
            n_fail++;
            $display("FAIL t3_zero_traffic: aw=%0d dones=%0d, required 0 1", aw_cnt, done_cnt);
        end
        flush_bench();
    endtask

    task automatic test_error_resp();
        bit ok;
        int exp_bursts;
        int exp_beats;
`ifdef AXI_DMA_W_ERR_ABORT_EN
        exp_bursts = 1;
`else
        exp_bursts = 3;
`endif
        exp_beats = exp_bursts * 16;
        err_first = 1'b1;
        push_beats(48, exp_beats);
        for (int i = 0; i < exp_bursts; i++) push_aw(32'(i * 32'h200), 8'd15);
        issue_cmd(32'h0, 16'd48);
        wait_done(2000, ok);
        n_checks++;
        if (!ok || done_cnt != 1 || aw_cnt != exp_bursts || w_cnt != exp_beats || b_cnt != exp_bursts) begin
            n_fail++;
            $display("FAIL t4_err_counts: done_seen=%0b dones=%0d aw=%0d w=%0d b=%0d, required 1 1 %0d %0d %0d",
                     ok, done_cnt, aw_cnt, w_cnt, b_cnt, exp_bursts, exp_beats, exp_bursts);
        end
        n_checks++;
        if (error !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL t4_err_flag: error=%0b busy=%0b, required 1 0", error, busy);
        end
        err_first = 1'b0;
        flush_bench();
    endtask

    task automatic test_backpressure();
        bit ok;
        aw_hold = 5; rand_w = 1'b1; rand_s = 1'b1;
        push_beats(16, 16);
        push_aw(32'h3000, 8'd15);
        issue_cmd(32'h3000, 16'd16);
        n_checks++;
        if (error !== 1'b0) begin
            n_fail++;
            $display("FAIL t5_err_clear: error=%0b after accepted start, required 0", error);
        end
        wait_done(4000, ok);
        n_checks++;
        if (!ok || done_cnt != 1 || aw_cnt != 1 || w_cnt != 16 || exp_w_q.size() != 0) begin
            n_fail++;
            $display("FAIL t5_counts: done_seen=%0b dones=%0d aw=%0d w=%0d w_left=%0d, required 1 1 1 16 0",
                     ok, done_cnt, aw_cnt, w_cnt, exp_w_q.size());
        end
        aw_hold = 0; rand_w = 1'b0; rand_s = 1'b0;
        flush_bench();
    endtask

    task automatic test_reset_mid();
        bit ok;
        int k = 0;
        push_beats(16, 16);
        push_aw(32'h0, 8'd15);
        issue_cmd(32'h0, 16'd16);
        while (w_cnt < 5 && k < 200) begin
            @(posedge clk); #2;
            k++;
        end
        n_checks++;
        if (w_cnt < 5) begin
            n_fail++;
            $display("FAIL t6_reach_data: beats=%0d, required 5", w_cnt);
        end
        rst = 1'b1;
        @(posedge clk); #2;
        n_checks++;
        if ({busy, done, error, m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready, s_ready} !== 8'h00) begin
            n_fail++;
            $display("FAIL t6_mid_reset: busy/done/error/awvalid/wvalid/wlast/bready/s_ready=%b, required 00000000",
                     {busy, done, error, m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready, s_ready});
        end
        rst = 1'b0;
        flush_bench();
        push_beats(4, 4);
        push_aw(32'h100, 8'd3);
        issue_cmd(32'h100, 16'd4);
        wait_done(2000, ok);
        n_checks++;
        if (!ok || done_cnt != 1 || aw_cnt != 1 || w_cnt != 4 || exp_aw_q.size() != 0) begin
            n_fail++;
            $display("FAIL t6_restart: done_seen=%0b dones=%0d aw=%0d w=%0d aw_left=%0d, required 1 1 1 4 0",
                     ok, done_cnt, aw_cnt, w_cnt, exp_aw_q.size());
        end
        flush_bench();
    endtask

    initial begin
        test_reset();
        test_three_bursts();
        test_4k_boundary();
        test_zero_total();
        test_error_resp();
        test_backpressure();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
